// File: rtl/decode_regfile_stage.sv
// ============================================================================
// Module   : decode_regfile_stage
// Purpose  : Decode stage. It holds the register file, decodes the
//            instruction fields and registers the operands and controls.
//            It sits between the fetch stage and the execute stage.
// Option   : DECODE_BYPASS_EN. When defined, a same-cycle writeback is
//            forwarded into ReadData_1/ReadData_2.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_regfile_stage #(
  parameter int REG_COUNT = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Stall,
  input  logic        WriteEnable,
  input  logic [4:0]  WriteAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData_1,
  output logic [31:0] ReadData_2,
  output logic [31:0] Imm,
  output logic        DataSrc,
  output logic [2:0]  ALUOp,
  output logic [4:0]  WriteSelect_S2
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;

  logic [31:0] r_regs [REG_COUNT];

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic [31:0] w_imm;
  logic [2:0]  w_alu_op;
  logic        w_data_src;
  logic [4:0]  w_dest;
  logic        w_write_ok;

  assign w_opcode = Instr[31:26];
  assign w_rs     = Instr[25:21];
  assign w_rt     = Instr[20:16];
  assign w_rd     = Instr[15:11];
  assign w_imm    = {{16{Instr[15]}}, Instr[15:0]};

  // Register 0 and any address beyond REG_COUNT are never written.
  assign w_write_ok = WriteEnable && (WriteAddr != 5'd0) &&
                      (int'(WriteAddr) < REG_COUNT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_ok) begin
      r_regs[WriteAddr] <= WriteData;
    end
  end

  always_comb begin
    w_rs_data = '0;
    if ((w_rs != 5'd0) && (int'(w_rs) < REG_COUNT)) begin
      w_rs_data = r_regs[w_rs];
`ifdef DECODE_BYPASS_EN
      if (WriteEnable && (WriteAddr == w_rs)) w_rs_data = WriteData;
`endif
    end
  end

  always_comb begin
    w_rt_data = '0;
    if ((w_rt != 5'd0) && (int'(w_rt) < REG_COUNT)) begin
      w_rt_data = r_regs[w_rt];
`ifdef DECODE_BYPASS_EN
      if (WriteEnable && (WriteAddr == w_rt)) w_rt_data = WriteData;
`endif
    end
  end

  // Unrecognised opcodes become NOPs. They have no writeback and ALU op 0.
  always_comb begin
    w_alu_op   = 3'd0;
    w_data_src = 1'b0;
    w_dest     = 5'd0;
    if (w_opcode == c_OP_RTYPE) begin
      w_alu_op = Instr[2:0];
      w_dest   = w_rd;
    end else if (w_opcode[5:3] == 3'b001) begin
      w_alu_op   = w_opcode[2:0];
      w_data_src = 1'b1;
      w_dest     = w_rt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ReadData_1     <= '0;
      ReadData_2     <= '0;
      Imm            <= '0;
      DataSrc        <= 1'b0;
      ALUOp          <= 3'd0;
      WriteSelect_S2 <= 5'd0;
    end else if (!Stall) begin
      ReadData_1     <= w_rs_data;
      ReadData_2     <= w_rt_data;
      Imm            <= w_imm;
      DataSrc        <= w_data_src;
      ALUOp          <= w_alu_op;
      WriteSelect_S2 <= w_dest;
    end
  end

endmodule

`default_nettype wire
